// File: rtl/genius_game_ctrl.sv
// -----------------------------------------------------------------------------
// genius_game_ctrl -- two-player "Genius" (Simon) memory game controller.
//
// Each round appends one pseudo-random color to the sequence, replays the whole
// sequence on outcolor (SHOW_CYCLES on, GAP_CYCLES blank per color), then waits
// for the active player to repeat it on btn_valid/btn_color. A fully correct
// round scores for the active player and hands the turn over; a wrong press or
// an idle timeout ends the game. Filling all MAX_LEN entries wins the game.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: new game (honoured in IDLE/OVER/WIN only)
//   btn_valid, btn_color  user press strobe and one-hot color (G,Y,R,B)
//   outcolor              one-hot color shown / echoed, 0 when blank
//   ready, busy           awaiting input / game in progress
//   correct, error        one-cycle round-complete / game-over pulses
//   player                active player (0 = P1, 1 = P2)
//   score_p1, score_p2    per-player completed rounds (saturating)
//   seq_len, user_pos     current sequence length / next expected index
// All outputs are registered.
// -----------------------------------------------------------------------------
module genius_game_ctrl #(
    parameter int MAX_LEN        = 32,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [3:0] btn_color,
    output logic [3:0] outcolor,
    output logic       ready,
    output logic       busy,
    output logic       correct,
    output logic       error,
    output logic       player,
    output logic [7:0] score_p1,
    output logic [7:0] score_p2,
    output logic [5:0] seq_len,
    output logic [4:0] user_pos
);

    localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0]  MAX_LEN_V = 6'(MAX_LEN);
    localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW, S_GAP, S_WAIT_IN, S_OVER, S_WIN
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  mem_q [MAX_LEN];
    logic [1:0]  mem_d [MAX_LEN];
    logic [5:0]  seq_len_q, seq_len_d;
    logic [4:0]  show_idx_q, show_idx_d;
    logic [4:0]  user_pos_q, user_pos_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        player_q, player_d;
    logic [7:0]  score_p1_q, score_p1_d;
    logic [7:0]  score_p2_q, score_p2_d;
    logic [3:0]  outcolor_q, outcolor_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        correct_q, correct_d;
    logic        error_q, error_d;
    logic [5:0]  last_idx;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // State register: every register of the block, outputs included.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 16'hACE1;
            // NOTE: the sequence memory is reset too, so a replay can never
            // show stale colors from before a reset.
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= 2'd0;
            seq_len_q  <= '0;
            show_idx_q <= '0;
            user_pos_q <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            player_q   <= 1'b0;
            score_p1_q <= '0;
            score_p2_q <= '0;
            outcolor_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            correct_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            mem_q      <= mem_d;
            seq_len_q  <= seq_len_d;
            show_idx_q <= show_idx_d;
            user_pos_q <= user_pos_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            player_q   <= player_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            outcolor_q <= outcolor_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            correct_q  <= correct_d;
            error_q    <= error_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a hold/default value first, so no path
        // through the case below can infer a latch.
        state_d    = state_q;
        mem_d      = mem_q;
        seq_len_d  = seq_len_q;
        show_idx_d = show_idx_q;
        user_pos_d = user_pos_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        player_d   = player_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        correct_d  = 1'b0;
        error_d    = 1'b0;
        last_idx   = seq_len_q - 6'd1;
        // Fibonacci taps 16,14,13,11 expressed on the right-shifting register.
        lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        unique case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    seq_len_d  = '0;
                    player_d   = 1'b0;
                    state_d    = S_ADD;
                end
            end
            S_ADD: begin
                mem_d[seq_len_q[IDX_W-1:0]] = lfsr_q[1:0];
                seq_len_d  = seq_len_q + 6'd1;
                show_idx_d = '0;
                cnt_d      = '0;
                state_d    = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if ({1'b0, show_idx_q} < last_idx) begin
                        show_idx_d = show_idx_q + 5'd1;
                        state_d    = S_SHOW;
                    end else begin
                        user_pos_d = '0;
                        tmo_d      = '0;
                        state_d    = S_WAIT_IN;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_IN: begin
                // A press always wins over the timeout in the same cycle.
                if (btn_valid) begin
                    if (btn_color == onehot(mem_q[user_pos_q[IDX_W-1:0]])) begin
                        if ({1'b0, user_pos_q} < last_idx) begin
                            user_pos_d = user_pos_q + 5'd1;
                            tmo_d      = '0;
                        end else begin
                            correct_d = 1'b1;
                            if (!player_q && score_p1_q != 8'hFF) score_p1_d = score_p1_q + 8'd1;
                            if ( player_q && score_p2_q != 8'hFF) score_p2_d = score_p2_q + 8'd1;
                            player_d = ~player_q;
                            state_d  = (seq_len_q == MAX_LEN_V) ? S_WIN : S_ADD;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_OVER;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_OVER;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: computed from the next state so the registered outputs
    // line up with the state they describe. mem_d is read so a color written
    // in ADD is visible on the very first SHOW cycle.
    always_comb begin
        outcolor_d = '0;
        if (state_q == S_WAIT_IN && btn_valid) begin
            outcolor_d = btn_color;
        end else if (state_d == S_SHOW) begin
            outcolor_d = onehot(mem_d[show_idx_d[IDX_W-1:0]]);
        end
        ready_d = (state_d == S_WAIT_IN);
        busy_d  = !(state_d inside {S_IDLE, S_OVER, S_WIN});
    end

    assign outcolor = outcolor_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign correct  = correct_q;
    assign error    = error_q;
    assign player   = player_q;
    assign score_p1 = score_p1_q;
    assign score_p2 = score_p2_q;
    assign seq_len  = seq_len_q;
    assign user_pos = user_pos_q;

endmodule
